// File: rtl/reg_read_stage.sv
// Register-read stage: reads operands, tracks in-flight writers in a busy scoreboard, interlocks RAW hazards.
// Optional writeback-to-operand forwarding is enabled by defining RAFI_RR_BYPASS_EN.
package rr_pkg;
  typedef struct packed {
    logic [3:0] aluOp;
    logic       rs1Enable;
    logic       rs2Enable;
    logic       regWriteEnable;
  } Op;

  typedef struct packed {
    logic       valid;
    logic [4:0] cause;
  } TrapInfo;
endpackage

module reg_read_stage #(
  parameter int REG_NUM = 32,
  parameter int XLEN    = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                decValid,
  input  logic [XLEN-1:0]     decPc,
  input  logic [31:0]         decInsn,
  input  rr_pkg::Op           decOp,
  input  logic [11:0]         decCsrAddr,
  input  rr_pkg::TrapInfo     decTrapInfo,
  output logic                decStall,
  output logic [4:0]          rfReadAddr1,
  output logic [4:0]          rfReadAddr2,
  input  logic [XLEN-1:0]     rfReadValue1,
  input  logic [XLEN-1:0]     rfReadValue2,
  input  logic                wbValid,
  input  logic                wbRegWrite,
  input  logic [4:0]          wbRd,
  input  logic [XLEN-1:0]     wbValue,
  input  logic                nextStall,
  input  logic                flush,
  output logic                rrValid,
  output logic [XLEN-1:0]     rrPc,
  output logic [31:0]         rrInsn,
  output rr_pkg::Op           rrOp,
  output logic [11:0]         rrCsrAddr,
  output rr_pkg::TrapInfo     rrTrapInfo,
  output logic [XLEN-1:0]     rrSrcValue1,
  output logic [XLEN-1:0]     rrSrcValue2
);

  logic                valid_q, valid_d;
  logic [XLEN-1:0]     pc_q, pc_d;
  logic [31:0]         insn_q, insn_d;
  rr_pkg::Op           op_q, op_d;
  logic [11:0]         csr_q, csr_d;
  rr_pkg::TrapInfo     trap_q, trap_d;
  logic [XLEN-1:0]     src1_q, src1_d;
  logic [XLEN-1:0]     src2_q, src2_d;
  logic [REG_NUM-1:0]  busy_q, busy_d;

  logic [4:0] rs1, rs2, rd;
  logic       wb_clr, byp1, byp2, hazard1, hazard2, hazard, issue;
  logic [XLEN-1:0] opnd1, opnd2;

  always_comb begin
    rs1    = decInsn[19:15];
    rs2    = decInsn[24:20];
    rd     = decInsn[11:7];
    wb_clr = wbValid && wbRegWrite && (wbRd != 5'd0);
`ifdef RAFI_RR_BYPASS_EN
    byp1   = wb_clr && (wbRd == rs1);
    byp2   = wb_clr && (wbRd == rs2);
`else
    byp1   = 1'b0;
    byp2   = 1'b0;
`endif
    hazard1  = decOp.rs1Enable && (rs1 != 5'd0) && busy_q[rs1] && !byp1;
    hazard2  = decOp.rs2Enable && (rs2 != 5'd0) && busy_q[rs2] && !byp2;
    hazard   = (hazard1 || hazard2) && !decTrapInfo.valid;
    issue    = decValid && !hazard && !nextStall && !flush;
    decStall = decValid && (hazard || nextStall) && !flush;

    // x0 and disabled sources read as zero regardless of regfile contents
    opnd1 = '0;
    if (decOp.rs1Enable && (rs1 != 5'd0)) opnd1 = byp1 ? wbValue : rfReadValue1;
    opnd2 = '0;
    if (decOp.rs2Enable && (rs2 != 5'd0)) opnd2 = byp2 ? wbValue : rfReadValue2;
  end

  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    insn_d  = insn_q;
    op_d    = op_q;
    csr_d   = csr_q;
    trap_d  = trap_q;
    src1_d  = src1_q;
    src2_d  = src2_q;
    busy_d  = busy_q;

    if (flush) begin
      valid_d = 1'b0;
      busy_d  = '0;
    end else begin
      if (wb_clr) busy_d[wbRd] = 1'b0;
      // the set is applied after the clear so a younger writer of the same rd keeps it busy
      if (issue && decOp.regWriteEnable && (rd != 5'd0) && !decTrapInfo.valid)
        busy_d[rd] = 1'b1;
      if (!nextStall) begin
        valid_d = issue;
        if (issue) begin
          pc_d   = decPc;
          insn_d = decInsn;
          op_d   = decOp;
          csr_d  = decCsrAddr;
          trap_d = decTrapInfo;
          src1_d = opnd1;
          src2_d = opnd2;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      insn_q  <= '0;
      op_q    <= '0;
      csr_q   <= '0;
      trap_q  <= '0;
      src1_q  <= '0;
      src2_q  <= '0;
      busy_q  <= '0;
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      insn_q  <= insn_d;
      op_q    <= op_d;
      csr_q   <= csr_d;
      trap_q  <= trap_d;
      src1_q  <= src1_d;
      src2_q  <= src2_d;
      busy_q  <= busy_d;
    end
  end

  assign rfReadAddr1 = rs1;
  assign rfReadAddr2 = rs2;
  assign rrValid     = valid_q;
  assign rrPc        = pc_q;
  assign rrInsn      = insn_q;
  assign rrOp        = op_q;
  assign rrCsrAddr   = csr_q;
  assign rrTrapInfo  = trap_q;
  assign rrSrcValue1 = src1_q;
  assign rrSrcValue2 = src2_q;

endmodule
